// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-slot alarm scheduler.
// Latency: n/a (types, constants and a constant helper function only).
// Backpressure: n/a.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE
    } state_t;

    // Alarm / wake time as BCD hh:mm digits
    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
    localparam logic [7:0] MAX_MIN_BCD  = 8'h59;

    // Two packed BCD digits to their binary value
    function automatic int bcd_to_bin(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Adds 0..59 minutes to a BCD hh:mm, carrying minutes into hours and wrapping 23 -> 00.
// Latency: purely combinational.
// Backpressure: none.
module bcd_time_add
    import alarm_pkg::*;
(
    input  bcd_hm_t    time_in,
    input  logic [5:0] add_min,
    output bcd_hm_t    time_out
);

    localparam int MIN_LAST  = bcd_to_bin(MAX_MIN_BCD);
    localparam int HOUR_LAST = bcd_to_bin(MAX_HOUR_BCD);

    logic [6:0] min_sum;
    logic [6:0] min_res;
    logic [5:0] hour_bin;
    logic [5:0] hour_sum;
    logic [5:0] hour_res;
    logic       min_carry;

    // Go through binary so every produced digit is a legal BCD digit
    always_comb begin
        min_sum   = 7'(time_in.m1) * 7'd10 + 7'(time_in.m0) + 7'(add_min);
        hour_bin  = 6'(time_in.h1) * 6'd10 + 6'(time_in.h0);
        min_carry = (min_sum > 7'(MIN_LAST));
        min_res   = min_carry ? (min_sum - 7'(MIN_LAST + 1)) : min_sum;
        hour_sum  = hour_bin + {5'd0, min_carry};
        hour_res  = (hour_sum > 6'(HOUR_LAST)) ? (hour_sum - 6'(HOUR_LAST + 1)) : hour_sum;
        time_out.m1 = 4'(min_res / 7'd10);
        time_out.m0 = 4'(min_res % 7'd10);
        time_out.h1 = 2'(hour_res / 6'd10);
        time_out.h0 = 4'(hour_res % 6'd10);
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm: per-second slot compare, ring / snooze / timeout sequencing. Macro ALARM_PENDING_EN adds a one-entry pending match.
// Latency: alarm rises one cycle after the matching tick; stop drops it on the next edge.
// Backpressure: none; matches arriving while ringing are dropped (or held once with ALARM_PENDING_EN).
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3,
    localparam int SW            = $clog2(NUM_SLOTS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick_1s,
    input  logic [1:0]    cur_hour1,
    input  logic [3:0]    cur_hour0,
    input  logic [3:0]    cur_min1,
    input  logic [3:0]    cur_min0,
    input  logic [3:0]    cur_sec0,
    input  logic [3:0]    cur_sec1,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_slot,
    input  logic [1:0]    cfg_hour1,
    input  logic [3:0]    cfg_hour0,
    input  logic [3:0]    cfg_min1,
    input  logic [3:0]    cfg_min0,
    input  logic          cfg_enable,
    input  logic          stop,
    input  logic          snooze,
    output logic          alarm,
    output logic [SW-1:0] ring_slot,
    output logic [2:0]    snooze_cnt,
    output logic          busy
);

    state_t          state;
    bcd_hm_t         slot_time [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_en;
    bcd_hm_t         cur_hm;
    bcd_hm_t         wake;
    bcd_hm_t         wake_nxt;
    logic [7:0]      ring_cnt;
    logic            minute_tick;
    logic            match_any;
    logic [SW-1:0]   match_idx;
    logic            wake_match;
    logic            start_vld;
    logic [SW-1:0]   start_slot;

    assign cur_hm      = {cur_hour1, cur_hour0, cur_min1, cur_min0};
    assign minute_tick = tick_1s && (cur_sec1 == 4'd0) && (cur_sec0 == 4'd0);
    assign wake_match  = minute_tick && (cur_hm == wake);

    bcd_time_add u_wake_add (
        .time_in  (cur_hm),
        .add_min  (6'(SNOOZE_MIN)),
        .time_out (wake_nxt)
    );

    // Slot configuration storage; a write only changes future matches
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_time[i] <= '0;
            end
            slot_en <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_we && (cfg_slot == SW'(i))) begin
                    slot_time[i] <= {cfg_hour1, cfg_hour0, cfg_min1, cfg_min0};
                    slot_en[i]   <= cfg_enable;
                end
            end
        end
    end

    // Lowest-index enabled slot whose hh:mm equals the time at second 00
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (minute_tick && slot_en[i] && (slot_time[i] == cur_hm)) begin
                match_any = 1'b1;
                match_idx = SW'(i);
            end
        end
    end

`ifdef ALARM_PENDING_EN
    logic          pend_vld;
    logic [SW-1:0] pend_slot;

    assign start_vld  = pend_vld || match_any;
    assign start_slot = pend_vld ? pend_slot : match_idx;

    // Hold the first match seen while ringing; IDLE consumes it (and keeps a coincident new match)
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_vld  <= 1'b0;
            pend_slot <= '0;
        end else if (state == ST_IDLE) begin
            pend_vld  <= pend_vld && match_any;
            pend_slot <= match_idx;
        end else if ((state == ST_RING) && match_any && !pend_vld) begin
            pend_vld  <= 1'b1;
            pend_slot <= match_idx;
        end
    end
`else
    assign start_vld  = match_any;
    assign start_slot = match_idx;
`endif

    // Ring / snooze / timeout sequencer with registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            alarm      <= 1'b0;
            busy       <= 1'b0;
            ring_slot  <= '0;
            snooze_cnt <= '0;
            ring_cnt   <= '0;
            wake       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_vld) begin
                        state      <= ST_RING;
                        alarm      <= 1'b1;
                        busy       <= 1'b1;
                        ring_slot  <= start_slot;
                        snooze_cnt <= '0;
                        ring_cnt   <= '0;
                    end
                end
                ST_RING: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        alarm <= 1'b0;
                        busy  <= 1'b0;
                    end else if (snooze && (snooze_cnt < 3'(MAX_SNOOZE))) begin
                        state      <= ST_SNOOZE;
                        alarm      <= 1'b0;
                        wake       <= wake_nxt;
                        snooze_cnt <= snooze_cnt + 3'd1;
                    end else if (tick_1s) begin
                        if (ring_cnt == 8'(RING_TIMEOUT_S - 1)) begin
                            state <= ST_IDLE;
                            alarm <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 8'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (match_any) begin
                        // a fresh slot match starts a new event
                        state      <= ST_RING;
                        alarm      <= 1'b1;
                        ring_slot  <= match_idx;
                        snooze_cnt <= '0;
                        ring_cnt   <= '0;
                    end else if (wake_match) begin
                        state    <= ST_RING;
                        alarm    <= 1'b1;
                        ring_cnt <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    alarm <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: directed time/config stimulus, output-change monitor.
// Latency: expected output tuples are queued before the stimulus that causes them.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_alarm_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1s = 1'b0;
    logic [1:0] cur_hour1 = '0;
    logic [3:0] cur_hour0 = '0, cur_min1 = '0, cur_min0 = '0, cur_sec0 = '0, cur_sec1 = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_slot = '0;
    logic [1:0] cfg_hour1 = '0;
    logic [3:0] cfg_hour0 = '0, cfg_min1 = '0, cfg_min0 = '0;
    logic       cfg_enable = 1'b0;
    logic       stop = 1'b0;
    logic       snooze = 1'b0;
    logic       alarm;
    logic [1:0] ring_slot;
    logic [2:0] snooze_cnt;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    logic [6:0] exp_q[$];
    logic [6:0] prev;
    bit         mon_on = 1'b0;

    alarm_scheduler dut (
        .clock(clock), .reset(reset), .tick_1s(tick_1s),
        .cur_hour1(cur_hour1), .cur_hour0(cur_hour0), .cur_min1(cur_min1),
        .cur_min0(cur_min0), .cur_sec0(cur_sec0), .cur_sec1(cur_sec1),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_hour1(cfg_hour1),
        .cfg_hour0(cfg_hour0), .cfg_min1(cfg_min1), .cfg_min0(cfg_min0),
        .cfg_enable(cfg_enable), .stop(stop), .snooze(snooze),
        .alarm(alarm), .ring_slot(ring_slot), .snooze_cnt(snooze_cnt), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] tup(input logic a, input logic b, input logic [1:0] s, input logic [2:0] c);
        return {a, b, s, c};
    endfunction

    // Expected output tuple {alarm, busy, ring_slot, snooze_cnt} for the next change
    task automatic exp_ev(input logic a, input logic b, input logic [1:0] s, input logic [2:0] c);
        exp_q.push_back(tup(a, b, s, c));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        cur_hour1 = hh[5:4]; cur_hour0 = hh[3:0];
        cur_min1  = mm[7:4]; cur_min0  = mm[3:0];
        cur_sec1  = ss[7:4]; cur_sec0  = ss[3:0];
    endtask

    task automatic cfg(input logic [1:0] s, input logic [7:0] hh, input logic [7:0] mm, input logic en);
        cfg_we = 1'b1; cfg_slot = s; cfg_enable = en;
        cfg_hour1 = hh[5:4]; cfg_hour0 = hh[3:0]; cfg_min1 = mm[7:4]; cfg_min0 = mm[3:0];
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic tick();
        tick_1s = 1'b1; cyc(1); tick_1s = 1'b0;
    endtask

    task automatic press(input logic st, input logic sn);
        stop = st; snooze = sn; cyc(1); stop = 1'b0; snooze = 1'b0;
    endtask

    // Monitor: every change of the output tuple must match the head of the queue
    always @(negedge clock) begin
        if (mon_on) begin
            logic [6:0] cur;
            cur = {alarm, busy, ring_slot, snooze_cnt};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_change", 32'(cur), 32'(prev));
                end else begin
                    chk("event", 32'(cur), 32'(exp_q.pop_front()));
                end
                prev = cur;
            end
        end
    end

    initial begin
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("reset_alarm", 32'(alarm), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ring_slot", 32'(ring_slot), 0);
        chk("reset_snooze_cnt", 32'(snooze_cnt), 0);
        prev   = {alarm, busy, ring_slot, snooze_cnt};
        mon_on = 1'b1;

        // Basic ring and stop on slot 2
        cfg(2'd2, 8'h07, 8'h30, 1'b1);
        set_time(8'h07, 8'h29, 8'h59); tick();
        set_time(8'h07, 8'h30, 8'h00);
        exp_ev(1, 1, 2'd2, 3'd0);
        tick();
        chk("ring_latency", 32'(alarm), 1);
        exp_ev(0, 0, 2'd2, 3'd0);
        press(1, 0);
        chk("stop_latency", 32'(alarm), 0);

        // Disabled slot, non-zero seconds, lowest index among equal slots
        cfg(2'd0, 8'h05, 8'h00, 1'b0);
        cfg(2'd1, 8'h06, 8'h00, 1'b1);
        cfg(2'd3, 8'h06, 8'h00, 1'b1);
        set_time(8'h05, 8'h00, 8'h00); tick();
        set_time(8'h06, 8'h00, 8'h30); tick();
        chk("no_ring_disabled_or_sec", 32'(busy), 0);
        set_time(8'h06, 8'h00, 8'h00);
        exp_ev(1, 1, 2'd1, 3'd0);
        tick();
        chk("lowest_slot_wins", 32'(ring_slot), 1);
        exp_ev(0, 0, 2'd1, 3'd0);
        press(1, 0);

        // Snooze across midnight, then exhaust snoozes
        cfg(2'd0, 8'h23, 8'h58, 1'b1);
        set_time(8'h23, 8'h58, 8'h00);
        exp_ev(1, 1, 2'd0, 3'd0); tick();
        set_time(8'h23, 8'h58, 8'h10);
        exp_ev(0, 1, 2'd0, 3'd1); press(0, 1);
        set_time(8'h00, 8'h02, 8'h00); tick();
        set_time(8'h00, 8'h03, 8'h00);
        exp_ev(1, 1, 2'd0, 3'd1); tick();
        exp_ev(0, 1, 2'd0, 3'd2); press(0, 1);
        set_time(8'h00, 8'h08, 8'h00);
        exp_ev(1, 1, 2'd0, 3'd2); tick();
        exp_ev(0, 1, 2'd0, 3'd3); press(0, 1);
        set_time(8'h00, 8'h13, 8'h00);
        exp_ev(1, 1, 2'd0, 3'd3); tick();
        press(0, 1);
        cyc(2);
        chk("fourth_snooze_ignored", 32'(alarm), 1);
        chk("snooze_cnt_max", 32'(snooze_cnt), 3);
        exp_ev(0, 0, 2'd0, 3'd3); press(1, 0);

        // Hour-digit carry 09:57+5 = 10:02, then stop+snooze together
        cfg(2'd3, 8'h09, 8'h57, 1'b1);
        set_time(8'h09, 8'h57, 8'h00);
        exp_ev(1, 1, 2'd3, 3'd0); tick();
        exp_ev(0, 1, 2'd3, 3'd1); press(0, 1);
        set_time(8'h10, 8'h02, 8'h00);
        exp_ev(1, 1, 2'd3, 3'd1); tick();
        exp_ev(0, 0, 2'd3, 3'd1); press(1, 1);

        // Ring timeout after 60 ticks
        set_time(8'h09, 8'h57, 8'h00);
        exp_ev(1, 1, 2'd3, 3'd0); tick();
        set_time(8'h09, 8'h57, 8'h01);
        repeat (59) tick();
        chk("ring_before_timeout", 32'(alarm), 1);
        exp_ev(0, 0, 2'd3, 3'd0); tick();
        chk("ring_after_timeout", 32'(alarm), 0);

        // Stop during snooze
        set_time(8'h09, 8'h57, 8'h00);
        exp_ev(1, 1, 2'd3, 3'd0); tick();
        exp_ev(0, 1, 2'd3, 3'd1); press(0, 1);
        exp_ev(0, 0, 2'd3, 3'd1); press(1, 0);

        // New slot match during snooze starts a fresh event
        cfg(2'd0, 8'h09, 8'h59, 1'b1);
        set_time(8'h09, 8'h57, 8'h00);
        exp_ev(1, 1, 2'd3, 3'd0); tick();
        exp_ev(0, 1, 2'd3, 3'd1); press(0, 1);
        set_time(8'h09, 8'h59, 8'h00);
        exp_ev(1, 1, 2'd0, 3'd0); tick();
        exp_ev(0, 0, 2'd0, 3'd0); press(1, 0);

        // Match while ringing: pending or dropped
        cfg(2'd0, 8'h08, 8'h00, 1'b1);
        cfg(2'd1, 8'h08, 8'h01, 1'b1);
        set_time(8'h08, 8'h00, 8'h00);
        exp_ev(1, 1, 2'd0, 3'd0); tick();
        set_time(8'h08, 8'h01, 8'h00); tick();
        set_time(8'h08, 8'h02, 8'h00);
        exp_ev(0, 0, 2'd0, 3'd0);
`ifdef ALARM_PENDING_EN
        exp_ev(1, 1, 2'd1, 3'd0);
        press(1, 0);
        cyc(1);
        chk("pending_rings", 32'(alarm), 1);
        exp_ev(0, 0, 2'd1, 3'd0); press(1, 0);
`else
        press(1, 0);
        cyc(1);
        chk("dropped_match_idle", 32'(alarm), 0);
`endif

        // Reset mid-ring clears outputs and slots
        set_time(8'h07, 8'h30, 8'h00);
        exp_ev(1, 1, 2'd2, 3'd0); tick();
        exp_ev(0, 0, 2'd0, 3'd0);
        reset = 1'b0; cyc(1); reset = 1'b1;
        chk("reset_drops_alarm", 32'(alarm), 0);
        tick();
        set_time(8'h06, 8'h00, 8'h00); tick();
        cyc(2);
        chk("slots_cleared", 32'(busy), 0);

        cyc(5);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Multi-slot alarm controller sitting beside the BCD timekeeping datapath. It stores NUM_SLOTS programmable alarm times, compares them against the running BCD time once per second and sequences the alarm output through ring, snooze and timeout. It replaces the single hard-wired alarm compare and drives the user-facing alarm output.

Parameters:
NUM_SLOTS, 4, number of alarm slots (2..8); slot index width SW = clog2(NUM_SLOTS)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
RING_TIMEOUT_S, 60, seconds of ringing before auto-stop (1..255)
MAX_SNOOZE, 3, snoozes allowed per ring event (0..7)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
tick_1s  in  1  single-cycle pulse once per second, synchronous to clock
cur_hour1/cur_hour0/cur_min1/cur_min0/cur_sec0/cur_sec1  in  2/4/4/4/4/4  current time, BCD digits
cfg_we  in  1  write strobe for slot configuration
cfg_slot  in  SW  slot to write
cfg_hour1/cfg_hour0/cfg_min1/cfg_min0  in  2/4/4/4  alarm time, BCD
cfg_enable  in  1  slot enable written with the time
stop  in  1  level; cancels ringing or snooze
snooze  in  1  level; requests snooze while ringing
alarm  out  1  high while in RING
ring_slot  out  SW  slot that caused the current event
snooze_cnt  out  3  snoozes used in the current event
busy  out  1  high in RING or SNOOZE

Behaviour:
- reset low at a clock edge: all slots cleared to 00:00 and disabled; state IDLE; alarm=0, ring_slot=0, snooze_cnt=0, busy=0; ring and wake counters cleared. Reset mid-ring drops alarm on the same edge.
- cfg_we: the slot is written on that edge. Writing does not affect an event already in RING or SNOOZE.
- Match: evaluated only in cycles where tick_1s=1, cur_sec=00, slot enabled and hh:mm equal. If several slots match, the lowest index wins.
- IDLE -> RING on match: ring_slot=winner, snooze_cnt=0, ring counter=0. alarm rises on the cycle after the tick (1-cycle latency).
- RING:
  - stop=1: go to IDLE; alarm=0 on the next edge. stop has priority over snooze.
  - snooze=1 with snooze_cnt<MAX_SNOOZE: load wake = current hh:mm + SNOOZE_MIN, increment snooze_cnt, go to SNOOZE.
  - snooze=1 with snooze_cnt==MAX_SNOOZE: ignored; stay in RING.
  - Ring counter increments on each tick_1s. When it reaches RING_TIMEOUT_S: go to IDLE.
  - Matches from other slots are dropped (see Optional Feature).
- SNOOZE: alarm=0, busy=1.
  - tick_1s with cur_sec=00 and hh:mm==wake: go to RING, ring counter=0, snooze_cnt kept.
  - stop=1: go to IDLE.
  - A new slot match: go to RING with the new ring_slot; snooze_cnt=0.
- Wake arithmetic is BCD.
  - Minutes carry at 59 -> 00 into hours.
  - Hours wrap 23 -> 00 (e.g. 23:58 + 5 = 00:03).
  - No invalid BCD digit is ever produced.
- Inputs are assumed valid BCD. Out-of-range cfg values are stored as-is and simply never match.

Optional Feature:
Macro ALARM_PENDING_EN.
- Defined: a one-entry pending register (valid + slot) captures the lowest-index match seen while in RING or SNOOZE; a later match does not overwrite a valid entry. On any transition to IDLE with pending valid, the FSM enters RING with that slot on the next cycle and clears pending. Reset clears pending.
- Undefined: such matches are silently dropped and no pending logic is synthesised.

Decomposition:
- Shared package alarm_pkg:
  - state enum (ST_IDLE, ST_RING, ST_SNOOZE)
  - BCD time struct/typedef (h1, h0, m1, m0)
  - constants MAX_HOUR_BCD=23 and MAX_MIN_BCD=59
- Sub-module bcd_time_add: combinational hh:mm BCD plus 0..59 minutes with carry and 24-hour wrap. It is unit-tested separately.

Test Plan:
- Slot 2 = 07:30 enabled; time reaches 07:30:00 tick -> alarm=1 next cycle, ring_slot=2; stop -> alarm=0 next edge.
- Slots 1 and 3 both = 06:00 -> ring_slot=1 only.
- Ring at 23:58, snooze -> wake=00:03, snooze_cnt=1; at 00:03:00 -> RING again. Four snooze presses with MAX_SNOOZE=3 -> fourth ignored, alarm stays 1.
- Ring with no input for 60 ticks -> alarm=0 after the 60th tick; stop and snooze asserted together -> IDLE, snooze_cnt unchanged.
- Reset low mid-RING -> alarm=0, all slots disabled; former alarm time passes -> no ring.
- With ALARM_PENDING_EN: slot 0 ringing 08:00, slot 1 = 08:01 matches; stop at 08:02 -> RING slot 1 one cycle later. Without the macro: IDLE stays.
